pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 132 +++++++++++++
 tb/tb_pc_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with optional branch delay slot and fetch handshake.
// Ports: CLK/RST, PCSrc/immediate/addr/rs redirect controls, fetch_ready in;
// curPC/fetch_valid/nextPC/in_delay out. `PC_EXC_EN adds exc_req in, epc out.
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 1,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] immediate,
  input  logic [25:0] addr,
  input  logic [31:0] rs,
  input  logic        fetch_ready,
`ifdef PC_EXC_EN
  input  logic        exc_req,
  output logic [31:0] epc,
`endif
  output logic [31:0] curPC,
  output logic        fetch_valid,
  output logic [31:0] nextPC,
  output logic        in_delay
);

  typedef enum logic {IDLE = 1'b0, DELAY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] pend_q, pend_d;
  logic        valid_q;
  logic [31:0] epc_q, epc_d;

  logic [31:0] seq, br, jr, jmp, tgt;
  logic        redirect, accept;
  logic [31:0] accept_pc;

  assign seq      = cur_q + 32'd4;
  assign br       = seq + {immediate[29:0], 2'b00};
  assign jr       = {rs[31:2], 2'b00};
  assign jmp      = {seq[31:28], addr, 2'b00};
  assign redirect = (PCSrc != 2'b00);
  assign accept   = valid_q & fetch_ready;

  always_comb begin
    tgt = seq;
    unique case (PCSrc)
      2'b00: tgt = seq;
      2'b01: tgt = br;
      2'b10: tgt = jr;
      2'b11: tgt = jmp;
    endcase
  end

  // PC loaded on the next accept, ignoring exceptions.
  always_comb begin
    accept_pc = seq;
    if (state_q == DELAY)
      accept_pc = pend_q;
    else if (redirect && DELAY_SLOT == 0)
      accept_pc = tgt;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cur_q   <= RESET_PC;
      pend_q  <= '0;
      valid_q <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      valid_q <= 1'b1;
      epc_q   <= epc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    epc_d   = epc_q;
    if (accept) begin
      cur_d = accept_pc;
      unique case (state_q)
        IDLE: begin
          if (redirect && DELAY_SLOT != 0) begin
            pend_d  = tgt;
            state_d = DELAY;
          end
        end
        DELAY: state_d = IDLE;
      endcase
    end
`ifdef PC_EXC_EN
    // Exceptions win over any fetch activity, including a pending target.
    if (exc_req) begin
      cur_d   = EXC_VECTOR;
      epc_d   = cur_q;
      pend_d  = '0;
      state_d = IDLE;
    end
`endif
  end

  // Outputs
  always_comb begin
    curPC       = cur_q;
    fetch_valid = valid_q;
    in_delay    = (state_q == DELAY);
    nextPC      = accept_pc;
`ifdef PC_EXC_EN
    if (exc_req)
      nextPC = EXC_VECTOR;
`endif
  end

`ifdef PC_EXC_EN
  assign epc = epc_q;
  logic unused_bits;
  assign unused_bits = ^{immediate[31:30], rs[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{immediate[31:30], rs[1:0], epc_q, epc_d,
                         EXC_VECTOR};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (delay slot on / off) share stimulus
// and are compared against a queue-based model of the fetch PC stream.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PCSrc;
  logic [31:0] immediate;
  logic [25:0] addr;
  logic [31:0] rs;
  logic        fetch_ready;
  logic        exc;

  logic [31:0] cur0, cur1, nxt0, nxt1;
  logic        val0, val1, dly0, dly1;
`ifdef PC_EXC_EN
  logic [31:0] epc0, epc1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_unit #(.DELAY_SLOT(1)) u_ds (
    .CLK(CLK), .RST(RST), .PCSrc(PCSrc), .immediate(immediate),
    .addr(addr), .rs(rs), .fetch_ready(fetch_ready),
`ifdef PC_EXC_EN
    .exc_req(exc), .epc(epc0),
`endif
    .curPC(cur0), .fetch_valid(val0), .nextPC(nxt0), .in_delay(dly0)
  );

  pc_unit #(.DELAY_SLOT(0)) u_nd (
    .CLK(CLK), .RST(RST), .PCSrc(PCSrc), .immediate(immediate),
    .addr(addr), .rs(rs), .fetch_ready(fetch_ready),
`ifdef PC_EXC_EN
    .exc_req(exc), .epc(epc1),
`endif
    .curPC(cur1), .fetch_valid(val1), .nextPC(nxt1), .in_delay(dly1)
  );

  // Model: index 0 has a delay slot, index 1 redirects immediately.
  logic [31:0] mpc [2];
  logic [31:0] mepc [2];
  logic        mval;
  logic        mknown = 1'b0;
  logic [31:0] q0 [$];

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    logic [31:0] s;
    s = pc + 32'd4;
    case (PCSrc)
      2'd1: return s + (immediate << 2);
      2'd2: return rs & 32'hFFFF_FFFC;
      2'd3: return (s & 32'hF000_0000) | ({6'd0, addr} << 2);
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] exp_next(input int d);
    if (exc) return 32'h0000_0080;
    if (d == 0 && q0.size() > 0) return q0[0];
    if (PCSrc == 2'd0 || d == 0) return mpc[d] + 32'd4;
    return tgt_of(mpc[d]);
  endfunction

  task automatic model_edge();
    logic [31:0] n [2];
    for (int d = 0; d < 2; d++) n[d] = exp_next(d);
    if (RST) begin
      mpc[0] = 32'd0; mpc[1] = 32'd0;
      mepc[0] = 32'd0; mepc[1] = 32'd0;
      q0.delete();
    end else if (exc) begin
      for (int d = 0; d < 2; d++) begin
        mepc[d] = mpc[d];
        mpc[d] = 32'h0000_0080;
      end
      q0.delete();
    end else if (mval && fetch_ready) begin
      if (q0.size() > 0) begin
        mpc[0] = q0.pop_front();
      end else begin
        if (PCSrc != 2'd0) q0.push_back(tgt_of(mpc[0]));
        mpc[0] = n[0];
      end
      mpc[1] = n[1];
    end
    mval = !RST;
    if (RST) mknown = 1'b1;
  endtask

  task automatic step(input logic r, input logic f, input logic [1:0] s,
                      input logic [31:0] i, input logic [25:0] a,
                      input logic [31:0] rv);
    RST = r; fetch_ready = f; PCSrc = s;
    immediate = i; addr = a; rs = rv;
    #1;
    if (mknown) begin
      chk("nextPC_ds", nxt0, exp_next(0));
      chk("nextPC_nd", nxt1, exp_next(1));
    end
    @(posedge CLK);
    model_edge();
    #1;
    chk("curPC_ds", cur0, mpc[0]);
    chk("curPC_nd", cur1, mpc[1]);
    chk("in_delay_ds", {31'd0, dly0}, {31'd0, q0.size() > 0});
    chk("in_delay_nd", {31'd0, dly1}, 32'd0);
    chk("valid_ds", {31'd0, val0}, {31'd0, mval});
    chk("valid_nd", {31'd0, val1}, {31'd0, mval});
`ifdef PC_EXC_EN
    chk("epc_ds", epc0, mepc[0]);
    chk("epc_nd", epc1, mepc[1]);
`endif
  endtask

  initial begin
    exc = 1'b0;
    mval = 1'b0;
    mpc[0] = 32'd0; mpc[1] = 32'd0;
    mepc[0] = 32'd0; mepc[1] = 32'd0;
    @(negedge CLK);

    // Reset and sequential fetch
    step(1, 1, 0, 0, 0, 0);
    chk("rst_pc", cur0, 32'h0);
    chk("rst_valid", {31'd0, val0}, 32'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("post_rst_valid", {31'd0, val0}, 32'd1);
    chk("seq0", cur0, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("seq4", cur0, 32'h4);
    step(0, 1, 0, 0, 0, 0);
    chk("seq8", cur1, 32'h8);
    step(0, 1, 0, 0, 0, 0);
    chk("seqC", cur0, 32'hC);

    // jr to 0x100; delay-slot unit takes the slot first
    step(0, 1, 2, 0, 0, 32'h0000_0101);
    chk("jr_nd", cur1, 32'h100);
    chk("jr_ds_slot", cur0, 32'h10);
    // branch in delay slot is discarded; no-slot unit branches
    step(0, 1, 1, 32'h10, 0, 0);
    chk("br_nd", cur1, 32'h144);
    chk("ds_at_100", cur0, 32'h100);
    step(0, 1, 1, 32'h10, 0, 0);
    chk("br_ds_slot", cur0, 32'h104);
    chk("br_ds_indelay", {31'd0, dly0}, 32'd1);
    // stall in DELAY with a jr on the inputs
    for (int k = 0; k < 3; k++) step(0, 0, 2, 0, 0, 32'h200);
    chk("stall_hold", cur0, 32'h104);
    step(0, 1, 2, 0, 0, 32'h200);
    chk("br_ds_target", cur0, 32'h144);
    chk("br_ds_done", {31'd0, dly0}, 32'd0);
    chk("jr200_nd", cur1, 32'h200);

    // j from 0x1000_0000
    step(0, 1, 2, 0, 0, 32'h1000_0000);
    step(0, 1, 3, 0, 26'h40, 0);
    chk("j_nd", cur1, 32'h1000_0100);
    chk("j_ds_jr", cur0, 32'h1000_0000);

    // wraparound
    step(0, 1, 2, 0, 0, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0);
    chk("wrap_nd", cur1, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("wrap_ds", cur0, 32'h0);

    // reset while in DELAY
    step(0, 1, 1, 32'h4, 0, 0);
    chk("pre_rst_delay", {31'd0, dly0}, 32'd1);
    step(1, 1, 2, 0, 0, 32'h40);
    chk("rst_delay_pc", cur0, 32'h0);
    chk("rst_delay_flag", {31'd0, dly0}, 32'd0);

`ifdef PC_EXC_EN
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 32'h300);
    step(0, 1, 0, 0, 0, 0);
    exc = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    exc = 1'b0;
    chk("exc_pc", cur0, 32'h80);
    chk("exc_epc", epc0, 32'h300);
    chk("exc_delay", {31'd0, dly0}, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
`ifdef PC_EXC_EN
      exc = ($urandom_range(0, 24) == 0);
`endif
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           2'($urandom), $urandom, 26'($urandom), $urandom);
    end
    exc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
